// File: rtl/sequential_divider.sv
// Unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Latency: result valid WIDTH cycles after the operand handshake; issue interval WIDTH+2.
// Backpressure: result held in DONE until dest_ready; no operands accepted until back in IDLE.

module sequential_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             dest_valid,
    input  logic             dest_ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] quotient;
        logic [WIDTH-1:0] remainder;
        logic             div_by_zero;
    } result_t;

    // ---------------- controller ----------------
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] step_cnt;
    logic          last_step;
    logic          load_en;
    logic          step_en;
    logic          done_en;

    assign last_step = (step_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (src_valid)  state_nxt = BUSY;
            BUSY:    if (last_step)  state_nxt = DONE;
            DONE:    if (dest_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // src_ready is masked by reset so it reads low for the whole reset pulse
    always_comb begin
        src_ready  = (state == IDLE) && !reset;
        dest_valid = (state == DONE);
        load_en    = src_ready && src_valid;
        step_en    = (state == BUSY);
        done_en    = (state == BUSY) && last_step;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (load_en) begin
            step_cnt <= '0;
        end else if (step_en) begin
            step_cnt <= step_cnt + CW'(1);
        end
    end

    // ---------------- datapath ----------------
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             dbz_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    result_t          res_q;

    // rem_q stays below the divisor, so its top bit is always 0 and the
    // one-bit-wider subtraction only sign-extends the trial difference.
    always_comb begin
        shifted   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial     = {rem_q, quo_q[WIDTH-1]} - {2'b00, dvs_q};
        trial_neg = trial[WIDTH+1];
        rem_nxt   = trial_neg ? shifted : trial[WIDTH:0];
        quo_nxt   = {quo_q[WIDTH-2:0], ~trial_neg};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            dbz_q <= 1'b0;
        end else if (load_en) begin
            rem_q <= '0;
            quo_q <= Dividend;
            dvs_q <= Divisor;
            dbz_q <= (Divisor == '0);
        end else if (step_en) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

    // Visible result only changes on entry to DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q <= '0;
        end else if (done_en) begin
            res_q <= '{quotient:    quo_nxt,
                       remainder:   rem_nxt[WIDTH-1:0],
                       div_by_zero: dbz_q};
        end
    end

    assign Quotient    = res_q.quotient;
    assign Remainder   = res_q.remainder;
    assign div_by_zero = res_q.div_by_zero;

endmodule

// File: doc/sequential_divider.md
# sequential_divider

Unsigned restoring divider producing one quotient bit per clock, the inverse companion of the team's sequential multiplier. It sits behind the same valid/ready operand/result handshake, so the two blocks can be placed back-to-back in an arithmetic pipeline, for example multiply-then-divide round-trip checks. Operands are captured on handshake. The result is held until the consumer accepts it.

## Interface
- WIDTH, 16, operand width in bits; must be ≥2.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- src_valid  input  1  producer has Dividend/Divisor valid.
- src_ready  output  1  block can accept operands (high only in IDLE).
- Dividend  input  WIDTH  unsigned numerator.
- Divisor  input  WIDTH  unsigned denominator.
- dest_valid  output  1  Quotient/Remainder/div_by_zero valid (high only in DONE).
- dest_ready  input  1  consumer accepts result.
- Quotient  output  WIDTH  floor(Dividend/Divisor).
- Remainder  output  WIDTH  Dividend mod Divisor.
- div_by_zero  output  1  captured Divisor was 0.

## Operation
- Reset values: src_ready=0 while reset is asserted, then 1 from the first cycle after release (IDLE). dest_valid=0. Quotient, Remainder and div_by_zero are 0.
- Internal registers:
  - Partial remainder R, WIDTH+1 bits.
  - Quotient/dividend shift register Q, WIDTH bits.
  - Divisor register D, WIDTH bits.
  - Step counter, $clog2(WIDTH)+1 bits.
  - Controller FSM.
- The block is split into a controller (FSM and counter, driving enables) and a datapath (R, Q, D, subtractor, mux), in the same way as the multiplier.
- IDLE: src_ready=1.
  - On src_valid && src_ready: load Q←Dividend, D←Divisor, R←0, counter←0, div_by_zero flag←(Divisor==0). Go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: src_ready=0, dest_valid=0. Each cycle performs one restoring step:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, D}.
  - If T is non-negative (MSB 0): R←T and shift 1 into Q.
  - Otherwise: R←{R[WIDTH-1:0], Q[WIDTH-1]} and shift 0 into Q.
  - counter←counter+1.
  - After step WIDTH completes (counter reaches WIDTH−1 at the edge), go to DONE.
- DONE: dest_valid=1. Quotient=Q, Remainder=R[WIDTH-1:0], div_by_zero=flag.
  - All three outputs are stable for every cycle DONE is held.
  - On dest_valid && dest_ready: go to IDLE.
- Divide by zero needs no special path. The algorithm naturally yields Quotient = all ones and Remainder = Dividend; div_by_zero=1 is reported alongside, with normal latency.
- Operand inputs are ignored outside the accepting edge. Changing them during BUSY or DONE has no effect.
- src_valid asserted in BUSY or DONE is not accepted; the producer must hold it until src_ready.
- Outputs Quotient, Remainder and div_by_zero keep their last values in IDLE and BUSY; they change only on entry to DONE. Only dest_valid qualifies them.
- Reset asserted in any state forces IDLE and clears all registers and outputs immediately. An in-flight operation is discarded with no result.

## Timing
- Accepting edge E0 (src_valid && src_ready). BUSY occupies the cycles after E0 through E_WIDTH.
- dest_valid rises exactly WIDTH edges after E0. For the default WIDTH=16, that is 16 cycles.
- dest_ready high when DONE is entered: result consumed at the first DONE edge, and src_ready is high on the next cycle.
- Minimum issue interval is WIDTH+2 cycles: accept, WIDTH steps, DONE, IDLE.
- No combinational path from src_valid to src_ready, or from dest_ready to dest_valid. Both outputs are decoded from the registered state.
- dest_ready held low: the block stays in DONE indefinitely with outputs frozen.

## Test plan
- 100/7, dest_ready=1 → dest_valid exactly 16 cycles after acceptance; Quotient=14, Remainder=2, div_by_zero=0; src_ready high the cycle after DONE.
- 0xFFFF/1 and 3/10 → (0xFFFF, 0) and (0, 3). Then 1000 random unsigned pairs checked against a floor-division/modulo model.
- 5/0 → Quotient=0xFFFF, Remainder=5, div_by_zero=1, same 16-cycle latency.
- dest_ready low for 10 cycles after dest_valid while the operand inputs toggle → outputs unchanged, src_ready=0 throughout; release accepts the result and returns to IDLE.
- Reset pulsed during BUSY (step 8 of 50000/3) → immediate src_ready=0/dest_valid=0 and zeroed outputs. After release, a new 50000/3 returns 16666 remainder 2 with full latency.
- Back-to-back: src_valid held high with 3 queued operand pairs and random dest_ready stalls → each pair accepted once, in order, results correct; no acceptance while busy or done.
